instr_fetch_unit: RTL and testbench

Instruction fetch stage for the RISC-V core: owns the fetch PC, issues word reads to instruction memory over a request/grant/response handshake, and buffers returned instruction words in an in-order queue. The head entry's instruction word, PC and PC+4 go to decode, where the instruction word drives the immediate extender's `Imm` input. Branch/jump redirects flush the queue and discard in-flight responses.

---
 rtl/instr_fetch_unit.sv | 142 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage.
// Owns the fetch PC and issues word reads to instruction memory over a req/gnt/rvalid
// handshake. Returned words are buffered in an in-order queue whose head goes to decode.
// A redirect flushes the queue and marks every in-flight response as stale.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   ImemReq/ImemAddr            read request valid / word address (always word aligned)
//   ImemGnt                     memory accepts the request this cycle
//   ImemRValid/ImemRData        in-order read response
//   Redirect/RedirectPC         taken branch/jump pulse and its target
//   InstrValid/InstrReady       queue head handshake with decode
//   Instr/InstrPC/InstrPCPlus4  head instruction word, its PC and PC+4
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemGnt,
  input  logic        ImemRValid,
  input  logic [31:0] ImemRData,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic        InstrValid,
  input  logic        InstrReady,
  output logic [31:0] Instr,
  output logic [31:0] InstrPC,
  output logic [31:0] InstrPCPlus4
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW:0]   DEPTH_W  = (CW + 1)'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [31:0]   NOP      = 32'h0000_0013;
  localparam logic [31:0]   RST_PC_A = {RESET_PC[31:2], 2'b00};

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;

  logic [31:0] instr_mem [DEPTH];
  logic [31:0] pc_mem    [DEPTH];

  logic [31:0] redirect_pc;
  logic [CW:0] credit_used;
  logic        grant;
  logic        resp;
  logic        keep;
  logic        pop;

  // Low address bits of a redirect target carry no meaning for word fetch.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^RedirectPC[1:0];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign redirect_pc = {RedirectPC[31:2], 2'b00};

  // Credit check only looks at registered state, so ImemReq never depends on
  // InstrReady or ImemRValid in the same cycle.
  assign credit_used = {1'b0, outstanding_q} + {1'b0, count_q};
  assign ImemReq     = rst_n & ~Redirect & (credit_used < DEPTH_W);
  assign ImemAddr    = fetch_pc_q;

  assign grant = ImemReq & ImemGnt;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign resp  = ImemRValid & (outstanding_q != '0);
  assign keep  = resp & (discard_q == '0) & ~Redirect;

  assign InstrValid   = (count_q != '0);
  assign pop          = InstrValid & InstrReady;
  assign Instr        = InstrValid ? instr_mem[rd_ptr_q] : NOP;
  assign InstrPC      = InstrValid ? pc_mem[rd_ptr_q] : resp_pc_q;
  assign InstrPCPlus4 = InstrPC + 32'd4;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q + CW'(grant) - CW'(resp);
    discard_d     = discard_q;
    count_d       = count_q + CW'(keep) - CW'(pop);
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;

    if (grant) fetch_pc_d = fetch_pc_q + 32'd4;
    if (resp && (discard_q != '0)) discard_d = discard_q - 1'b1;
    if (keep) begin
      resp_pc_d = resp_pc_q + 32'd4;
      wr_ptr_d  = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);

    if (Redirect) begin
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      // Every request still in flight after this cycle belongs to the old path.
      discard_d  = outstanding_q - CW'(resp);
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RST_PC_A;
      resp_pc_q     <= RST_PC_A;
      outstanding_q <= '0;
      discard_q     <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  // Queue storage needs no reset: entries are only visible when counted valid.
  always_ff @(posedge clk) begin
    if (keep) begin
      instr_mem[wr_ptr_q] <= ImemRData;
      pc_mem[wr_ptr_q]    <= resp_pc_q;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemGnt = 1'b0;
  logic        ImemRValid = 1'b0;
  logic [31:0] ImemRData = '0;
  logic        Redirect = 1'b0;
  logic [31:0] RedirectPC = '0;
  logic        InstrValid;
  logic        InstrReady = 1'b0;
  logic [31:0] Instr;
  logic [31:0] InstrPC;
  logic [31:0] InstrPCPlus4;

  instr_fetch_unit #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ImemReq      (ImemReq),
    .ImemAddr     (ImemAddr),
    .ImemGnt      (ImemGnt),
    .ImemRValid   (ImemRValid),
    .ImemRData    (ImemRData),
    .Redirect     (Redirect),
    .RedirectPC   (RedirectPC),
    .InstrValid   (InstrValid),
    .InstrReady   (InstrReady),
    .Instr        (Instr),
    .InstrPC      (InstrPC),
    .InstrPCPlus4 (InstrPCPlus4)
  );

  always #5 clk = ~clk;

  // Memory model: granted requests waiting for their response, tagged with the
  // fetch path (epoch) they were issued on.
  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } mreq_t;

  mreq_t       memq[$];
  logic [31:0] kept_q[$];   // PCs accepted into the fetch queue, oldest first
  int          epoch;
  int          cyc;
  int          lat;
  int          stall_pct;
  int          n_vec;
  int          n_err;
  logic [31:0] exp_fetch;
  logic        drv_gnt;
  logic        drv_ready;
  logic        drv_redir;
  logic [31:0] drv_rpc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5C3_0000;
  endfunction

  // One clock cycle: entered and left at the falling edge.
  task automatic tick();
    logic  rv;
    logic  stale;
    logic  exp_req;
    mreq_t head;
    ImemGnt    = drv_gnt;
    InstrReady = drv_ready;
    Redirect   = drv_redir;
    RedirectPC = drv_rpc;
    rv = (memq.size() > 0) && (memq[0].due <= cyc) && ($urandom_range(99) >= stall_pct);
    ImemRValid = rv;
    ImemRData  = rv ? mem_word(memq[0].addr) : $urandom;
    #1;
    exp_req = !drv_redir && ((memq.size() + kept_q.size()) < DEPTH);
    n_vec++;
    if (ImemReq !== exp_req) begin
      n_err++;
      $display("FAIL imem_req cyc=%0d got=%b exp=%b", cyc, ImemReq, exp_req);
    end
    n_vec++;
    if (InstrValid !== (kept_q.size() != 0)) begin
      n_err++;
      $display("FAIL instr_valid cyc=%0d got=%b exp=%b", cyc, InstrValid, kept_q.size() != 0);
    end
    if (kept_q.size() != 0) begin
      n_vec++;
      if (InstrPC !== kept_q[0] || Instr !== mem_word(kept_q[0]) ||
          InstrPCPlus4 !== kept_q[0] + 32'd4) begin
        n_err++;
        $display("FAIL head cyc=%0d got pc=%h instr=%h pc4=%h exp pc=%h instr=%h pc4=%h",
                 cyc, InstrPC, Instr, InstrPCPlus4, kept_q[0], mem_word(kept_q[0]),
                 kept_q[0] + 32'd4);
      end
    end
    if (ImemReq === 1'b1) begin
      n_vec++;
      if (ImemAddr !== exp_fetch) begin
        n_err++;
        $display("FAIL imem_addr cyc=%0d got=%h exp=%h", cyc, ImemAddr, exp_fetch);
      end
    end
    // Reference: handoff, then response, then redirect, then new grant.
    if ((kept_q.size() != 0) && drv_ready) void'(kept_q.pop_front());
    if (rv) begin
      head  = memq.pop_front();
      stale = (head.epoch != epoch) || drv_redir;
      if (!stale) kept_q.push_back(head.addr);
    end
    if (drv_redir) begin
      kept_q.delete();
      epoch++;
      exp_fetch = {drv_rpc[31:2], 2'b00};
    end
    if (exp_req && drv_gnt) begin
      memq.push_back('{addr: exp_fetch, due: cyc + lat, epoch: epoch});
      exp_fetch = exp_fetch + 32'd4;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    n_vec++;
    if (InstrValid !== 1'b0 || ImemReq !== 1'b0) begin
      n_err++;
      $display("FAIL %s_ctrl got valid=%b req=%b exp 0/0", tag, InstrValid, ImemReq);
    end
    n_vec++;
    if (Instr !== 32'h0000_0013) begin
      n_err++;
      $display("FAIL %s_instr got=%h exp=00000013", tag, Instr);
    end
    n_vec++;
    if (InstrPC !== RESET_PC || InstrPCPlus4 !== RESET_PC + 32'd4) begin
      n_err++;
      $display("FAIL %s_pc got=%h/%h exp=%h/%h", tag, InstrPC, InstrPCPlus4, RESET_PC,
               RESET_PC + 32'd4);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n     = 1'b1;
    cyc       = 0;
    drv_gnt   = 1'b1;
    drv_ready = 1'b1;
    drv_redir = 1'b0;
    drv_rpc   = '0;
    ImemGnt   = 1'b1;
    InstrReady = 1'b1;
    #1;
    n_vec++;
    if (ImemReq !== 1'b1 || ImemAddr !== RESET_PC) begin
      n_err++;
      $display("FAIL first_req got req=%b addr=%h exp 1/%h", ImemReq, ImemAddr, RESET_PC);
    end
  endtask

  task automatic test_streaming();
    for (int k = 0; k < 20; k++) begin
      if (k >= 2) begin
        n_vec++;
        if (InstrValid !== 1'b1 || InstrPC !== 32'(4 * (k - 2))) begin
          n_err++;
          $display("FAIL stream k=%0d got valid=%b pc=%h exp 1/%h", k, InstrValid, InstrPC,
                   32'(4 * (k - 2)));
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    drv_ready = 1'b0;
    repeat (10) tick();
    n_vec++;
    if (ImemReq !== 1'b0 || InstrValid !== 1'b1) begin
      n_err++;
      $display("FAIL full_queue got req=%b valid=%b exp 0/1", ImemReq, InstrValid);
    end
    drv_ready = 1'b1;
    repeat (12) tick();
  endtask

  task automatic test_redirect_inflight();
    bit found;
    drv_gnt   = 1'b0;
    drv_ready = 1'b1;
    lat       = 3;
    repeat (8) tick();
    drv_gnt = 1'b1;
    repeat (2) tick();
    drv_redir = 1'b1;
    drv_rpc   = 32'h0000_0100;
    tick();
    drv_redir = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (InstrValid === 1'b1) found = 1'b1;
      else tick();
    end
    n_vec++;
    if (!found || InstrPC !== 32'h0000_0100) begin
      n_err++;
      $display("FAIL redirect_first got found=%b pc=%h exp 1/00000100", found, InstrPC);
    end
    repeat (6) tick();
  endtask

  task automatic test_redirect_collide();
    lat = 1;
    drv_gnt = 1'b1;
    drv_ready = 1'b1;
    repeat (6) tick();
    n_vec++;
    if (InstrValid !== 1'b1) begin
      n_err++;
      $display("FAIL collide_head got valid=%b exp 1", InstrValid);
    end
    drv_redir = 1'b1;
    drv_rpc   = 32'h0000_0203;
    tick();
    drv_redir = 1'b0;
    Redirect  = 1'b0;
    #1;
    n_vec++;
    if (ImemReq !== 1'b1 || ImemAddr !== 32'h0000_0200) begin
      n_err++;
      $display("FAIL collide_next got req=%b addr=%h exp 1/00000200", ImemReq, ImemAddr);
    end
    repeat (6) tick();
  endtask

  task automatic test_wrap_and_reset();
    drv_redir = 1'b1;
    drv_rpc   = 32'hFFFF_FFFC;
    tick();
    drv_redir = 1'b0;
    Redirect  = 1'b0;
    #1;
    n_vec++;
    if (ImemReq !== 1'b1 || ImemAddr !== 32'hFFFF_FFFC) begin
      n_err++;
      $display("FAIL wrap_a got req=%b addr=%h exp 1/fffffffc", ImemReq, ImemAddr);
    end
    tick();
    n_vec++;
    if (ImemReq !== 1'b1 || ImemAddr !== 32'h0000_0000) begin
      n_err++;
      $display("FAIL wrap_b got req=%b addr=%h exp 1/00000000", ImemReq, ImemAddr);
    end
    repeat (5) tick();
    // Drop reset between clock edges; outputs must clear without a clock.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    memq.delete();
    kept_q.delete();
    epoch++;
    exp_fetch  = RESET_PC;
    ImemRValid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) tick();
  endtask

  task automatic test_random();
    for (int seg = 0; seg < 10; seg++) begin
      lat       = $urandom_range(4, 1);
      stall_pct = $urandom_range(40, 0);
      for (int i = 0; i < 300; i++) begin
        drv_gnt   = ($urandom_range(3) != 0);
        drv_ready = ($urandom_range(3) != 0);
        drv_redir = ($urandom_range(24) == 0);
        drv_rpc   = $urandom;
        tick();
      end
    end
    drv_redir = 1'b0;
    stall_pct = 0;
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    epoch     = 0;
    cyc       = 0;
    lat       = 1;
    stall_pct = 0;
    exp_fetch = RESET_PC;
    drv_gnt   = 1'b0;
    drv_ready = 1'b0;
    drv_redir = 1'b0;
    drv_rpc   = '0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_collide();
    test_wrap_and_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
